alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Function : Two-requester round-robin front end for one shared combinational
//            ALU, using a registered operand path and a held response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [3:0]      req0_op,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req1_op,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_invalid,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_invalid,

    output logic            busy,
    output logic [15:0]     err_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [15:0] C_ERR_MAX = 16'hFFFF;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_last_grant;
    logic            r_owner;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_control;
    logic [XLEN-1:0] r_rsp_result;
    logic            r_rsp_invalid;
    logic [15:0]     r_err_count;

    logic            w_grant_sel;
    logic            w_req_fire;
    logic            w_rsp_fire;

    // Contention goes to whoever was not served last; otherwise the sole requester wins.
    assign w_grant_sel = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_req_fire  = req0_ready || req1_ready;
    assign w_rsp_fire  = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_fire) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic; everything handshake-related is forced low while rst is high
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            busy = (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    req0_ready = req0_valid && !w_grant_sel;
                    req1_ready = req1_valid &&  w_grant_sel;
                end
                S_RESP: begin
                    rsp0_valid = !r_owner;
                    rsp1_valid =  r_owner;
                end
                default: begin
                    req0_ready = 1'b0;
                    req1_ready = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, result capture, error counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= 4'b0000;
            r_rsp_result  <= '0;
            r_rsp_invalid <= 1'b0;
            r_err_count   <= 16'd0;
        end else begin
            if (w_req_fire) begin
                r_alu_a       <= w_grant_sel ? req1_a  : req0_a;
                r_alu_b       <= w_grant_sel ? req1_b  : req0_b;
                r_alu_control <= w_grant_sel ? req1_op : req0_op;
                r_owner       <= w_grant_sel;
                r_last_grant  <= w_grant_sel;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result  <= alu_result;
                r_rsp_invalid <= alu_invalid;
            end
            if (w_rsp_fire && r_rsp_invalid && (r_err_count != C_ERR_MAX)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;
    assign rsp_result  = r_rsp_result;
    assign rsp_invalid = r_rsp_invalid;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Function : Directed vector bench for alu_arbiter with a small reference ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int XLEN = 64;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]      req0_op, req1_op;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_invalid;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [3:0]      alu_control;
    logic            alu_invalid;
    logic            busy;
    logic [15:0]     err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp_result  (rsp_result),
        .rsp_invalid (rsp_invalid),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_invalid (alu_invalid),
        .busy        (busy),
        .err_count   (err_count)
    );

    // Shared combinational ALU; unsupported codes return zero with the invalid flag.
    always_comb begin
        alu_result  = '0;
        alu_invalid = 1'b0;
        case (alu_control)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            default: alu_invalid = 1'b1;
        endcase
    end

    typedef struct {
        logic            req;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
        logic [XLEN-1:0] exp_res;
        logic            exp_inv;
        int              delay;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic rdy;
        @(posedge clk); #1;
        if (v.req) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
        end
        n = 0;
        @(negedge clk);
        rdy = v.req ? req1_ready : req0_ready;
        while (!rdy && n < 10) begin
            @(negedge clk);
            rdy = v.req ? req1_ready : req0_ready;
            n++;
        end
        check("req_ready", rdy, 1);
        check("other_ready", v.req ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("exec_busy", busy, 1);
        check("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("exec_alu_a", alu_a, v.a);
        check("exec_alu_b", alu_b, v.b);
        check("exec_alu_control", alu_control, v.op);
        @(negedge clk);
        check("rsp_valid", {rsp1_valid, rsp0_valid}, v.req ? 2'b10 : 2'b01);
        check("rsp_result", rsp_result, v.exp_res);
        check("rsp_invalid", rsp_invalid, v.exp_inv);
        for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", {rsp1_valid, rsp0_valid}, v.req ? 2'b10 : 2'b01);
            check("hold_rsp_result", rsp_result, v.exp_res);
        end
        if (v.req) rsp1_ready = 1'b1;
        else       rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        if (v.exp_inv) exp_err++;
        @(negedge clk);
        check("idle_after_rsp", {busy, rsp1_valid, rsp0_valid}, 0);
        check("err_count", err_count, exp_err);
    endtask

    initial begin
        vecs[0] = '{1'b0, 64'd5,    64'd3,    OP_ADD,  64'd8,    1'b0, 0};
        vecs[1] = '{1'b1, 64'd10,   64'd4,    OP_SUB,  64'd6,    1'b0, 2};
        vecs[2] = '{1'b0, 64'hF0,   64'hFF,   OP_XOR,  64'h0F,   1'b0, 0};
        vecs[3] = '{1'b1, 64'h1234, 64'h5678, 4'b1111, 64'd0,    1'b1, 0};
        vecs[4] = '{1'b0, 64'hFF00FF00, 64'h0FF00FF0, OP_AND, 64'h0F000F00, 1'b0, 0};
        vecs[5] = '{1'b1, 64'hF0,   64'h0F,   OP_OR,   64'hFF,   1'b0, 1};
        vecs[6] = '{1'b0, {64{1'b1}}, 64'd1,  OP_ADD,  64'd0,    1'b0, 0};
        vecs[7] = '{1'b1, 64'd0,    64'd1,    OP_SUB,  {64{1'b1}}, 1'b0, 0};
        vecs[8] = '{1'b0, 64'd77,   64'd88,   4'b1001, 64'd0,    1'b1, 3};

        // Reset with both requesters already asserting.
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 64'd10;  req0_b = 64'd4;   req0_op = OP_SUB;
        req1_valid = 1'b1; req1_a = 64'hF0;  req1_b = 64'hFF;  req1_op = OP_XOR;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rst_err_count", err_count, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_control", alu_control, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_invalid", rsp_invalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Continuous contention: req0 first, then strict alternation.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("both_req0_ready", req0_ready, (k == 0 || k == 6));
            check("both_req1_ready", req1_ready, (k == 3));
            check("both_rsp0_valid", rsp0_valid, (k == 2));
            check("both_rsp1_valid", rsp1_valid, (k == 5));
            if (k == 2) check("both_result0", rsp_result, 64'd6);
            if (k == 5) check("both_result1", rsp_result, 64'h0F);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(negedge clk);
        check("both_drain_idle", busy, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Held response blocks a waiting requester.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 64'd7; req0_b = 64'd2; req0_op = OP_ADD;
        @(negedge clk);
        check("hold_req0_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd1; req1_op = OP_ADD;
        @(negedge clk);
        check("hold_exec_req1_ready", req1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp0_valid", rsp0_valid, 1);
            check("hold_result", rsp_result, 64'd9);
            check("hold_req1_ready", req1_ready, 0);
        end
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        @(negedge clk);
        check("hold_req1_after", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold_rsp1_valid", rsp1_valid, 1);
        check("hold_rsp1_result", rsp_result, 64'd2);
        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp1_ready = 1'b0;

        // Reset during EXEC aborts the operation.
        req1_valid = 1'b1; req1_a = 64'd50; req1_b = 64'd1; req1_op = OP_SUB;
        @(negedge clk);
        check("abort_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 64'd100; req0_b = 64'd23; req0_op = OP_ADD;
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("abort_rst_ready", {req1_ready, req0_ready}, 0);
        check("abort_rst_busy", busy, 0);
        check("abort_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 0;
        @(negedge clk);
        check("abort_req0_first", {req1_ready, req0_ready}, 2'b01);
        check("abort_err_count", err_count, 0);
        check("abort_rsp1_valid", rsp1_valid, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("abort_exec_rsp1", rsp1_valid, 0);
        @(negedge clk);
        check("abort_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b01);
        check("abort_result", rsp_result, 64'd123);
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(negedge clk);
        check("abort_final_idle", {busy, rsp1_valid, rsp0_valid}, 0);
        check("abort_final_err", err_count, exp_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
